pool_stream_2x2: RTL and testbench

//   Streaming 2x2, stride-2 max-pool stage for the CNN datapath. Accepts one pixel per cycle of a

---
 rtl/pool_stream_2x2.sv | 136 +++++++++++++
 tb/tb_pool_stream_2x2.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_stream_2x2.sv
// Streaming 2x2 stride-2 pooling stage over a raster-scanned IMG_W x IMG_H map, valid/ready both sides.
// Define POOL_AVG_EN to add the mode_avg port (per-frame choice of average or max pooling).
module pool_stream_2x2 #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int SIGNED     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
`ifdef POOL_AVG_EN
  ,
  input  logic                  mode_avg
`endif
);

`ifdef POOL_AVG_EN
  localparam int LW = DATA_WIDTH + 2;
`else
  localparam int LW = DATA_WIDTH;
`endif
  localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int NH = IMG_W / 2;
  localparam int AW = (NH > 1) ? $clog2(NH) : 1;

  function automatic logic [LW-1:0] ext(input logic [DATA_WIDTH-1:0] d);
    if (SIGNED != 0) return LW'($signed(d));
    else             return LW'(d);
  endfunction

  function automatic logic [LW-1:0] max2(input logic [LW-1:0] a, input logic [LW-1:0] b);
    if (SIGNED != 0) return ($signed(a) > $signed(b)) ? a : b;
    else             return (a > b) ? a : b;
  endfunction

`ifdef POOL_AVG_EN
  // Sum of four pixels fits LW bits; the floor shift keeps the sign when SIGNED.
  function automatic logic [DATA_WIDTH-1:0] avg_out(input logic [LW-1:0] s);
    if (SIGNED != 0) return DATA_WIDTH'($signed(s) >>> 2);
    else             return DATA_WIDTH'(s >> 2);
  endfunction
`endif

  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [LW-1:0]         hold_q;
  logic [LW-1:0]         lb_q [NH];
  logic                  out_valid_q, out_last_q;
  logic [DATA_WIDTH-1:0] out_data_q;

  logic                  in_fire, out_fire, col_last, row_last, emit;
  logic [AW-1:0]         lb_idx;
  logic [LW-1:0]         px, pair, quad;
  logic [DATA_WIDTH-1:0] res;

  assign in_ready = rst_n && (!out_valid_q || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;
  assign col_last = (col_q == CW'(IMG_W - 1));
  assign row_last = (row_q == RW'(IMG_H - 1));
  assign emit     = in_fire && row_q[0] && col_q[0];
  assign lb_idx   = AW'(col_q >> 1);
  assign px       = ext(in_data);

`ifdef POOL_AVG_EN
  logic mode_q;
  // mode_q is latched on the (0,0) pixel, always before any odd column uses it.
  assign pair = mode_q ? (hold_q + px) : max2(hold_q, px);
  assign quad = mode_q ? (lb_q[lb_idx] + pair) : max2(lb_q[lb_idx], pair);
  assign res  = mode_q ? avg_out(quad) : quad[DATA_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n)                                    mode_q <= 1'b0;
    else if (in_fire && col_q == '0 && row_q == '0) mode_q <= mode_avg;
  end
`else
  assign pair = max2(hold_q, px);
  assign quad = max2(lb_q[lb_idx], pair);
  assign res  = quad[DATA_WIDTH-1:0];
`endif

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (in_fire) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      hold_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      if (in_fire && !col_q[0]) hold_q <= px;
      // A new result takes precedence; it replaces an entry being accepted this cycle.
      if (emit) begin
        out_valid_q <= 1'b1;
        out_data_q  <= res;
        out_last_q  <= row_last && col_last;
      end else if (out_fire) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

  // Line buffer holds even-row pair results; every entry is written before it is read.
  always_ff @(posedge clk) begin
    if (in_fire && !row_q[0] && col_q[0]) lb_q[lb_idx] <= pair;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_pool_stream_2x2.sv
// Scoreboard bench for pool_stream_2x2 (4x4 frames): a signed and an unsigned instance share stimulus.
module tb_pool_stream_2x2;
  localparam int DW = 16;

  typedef logic [DW-1:0] frame_t [16];
  typedef logic [DW-1:0] exp4_t [4];
  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            lat;
  } exp_t;

  logic          clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1, mode_avg = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready_s, in_ready_u, vld_s, vld_u, last_s, last_u;
  logic [DW-1:0] data_s, data_u;

  int   cyc = 0, errors = 0, checks = 0, accepted = 0;
  exp_t q_s[$], q_u[$];
  exp_t e_s, e_u;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pool_stream_2x2 #(.DATA_WIDTH(DW), .IMG_W(4), .IMG_H(4), .SIGNED(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
    .out_valid(vld_s), .out_ready(out_ready), .out_data(data_s), .out_last(last_s)
`ifdef POOL_AVG_EN
    , .mode_avg(mode_avg)
`endif
  );

  pool_stream_2x2 #(.DATA_WIDTH(DW), .IMG_W(4), .IMG_H(4), .SIGNED(0)) dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u), .in_data(in_data),
    .out_valid(vld_u), .out_ready(out_ready), .out_data(data_u), .out_last(last_u)
`ifdef POOL_AVG_EN
    , .mode_avg(mode_avg)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitors: pop and compare on every output transfer; check hold stability while stalled.
  logic          stall_s = 1'b0, stall_u = 1'b0, hl_s, hl_u;
  logic [DW-1:0] hd_s, hd_u;

  always @(negedge clk) begin
    if (rst_n && vld_s) begin
      if (stall_s) begin
        check("stable_data_s", data_s, hd_s);
        check("stable_last_s", last_s, hl_s);
      end
      if (out_ready) begin
        stall_s = 1'b0;
        if (q_s.size() == 0) begin
          check("unexpected_out_s", 1'b1, 1'b0);
        end else begin
          e_s = q_s.pop_front();
          check("data_s", data_s, e_s.data);
          check("last_s", last_s, e_s.last);
          if (e_s.lat >= 0) check("latency_s", cyc, e_s.lat + 1);
        end
      end else begin
        stall_s = 1'b1; hd_s = data_s; hl_s = last_s;
      end
    end else begin
      stall_s = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n && vld_u) begin
      if (stall_u) begin
        check("stable_data_u", data_u, hd_u);
        check("stable_last_u", last_u, hl_u);
      end
      if (out_ready) begin
        stall_u = 1'b0;
        if (q_u.size() == 0) begin
          check("unexpected_out_u", 1'b1, 1'b0);
        end else begin
          e_u = q_u.pop_front();
          check("data_u", data_u, e_u.data);
          check("last_u", last_u, e_u.last);
          if (e_u.lat >= 0) check("latency_u", cyc, e_u.lat + 1);
        end
      end else begin
        stall_u = 1'b1; hd_u = data_u; hl_u = last_u;
      end
    end else begin
      stall_u = 1'b0;
    end
  end

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send_px(input logic [DW-1:0] d, input bit push, input logic [DW-1:0] es,
                         input logic [DW-1:0] eu, input bit is_last, input bit lat_en);
    int t = 0;
    int acc;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready_s && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready_s) begin
      check("in_ready_timeout", 1'b0, 1'b1);
      in_valid = 1'b0;
      return;
    end
    acc = cyc;
    @(posedge clk);
    accepted++;
    if (push) begin
      q_s.push_back('{data: es, last: is_last, lat: (lat_en ? acc : -1)});
      q_u.push_back('{data: eu, last: is_last, lat: (lat_en ? acc : -1)});
    end
    @(negedge clk);
  endtask

  task automatic send_frame(input frame_t px, input exp4_t es, input exp4_t eu, input bit lat_en,
                            input logic m0, input logic mrest);
    for (int i = 0; i < 16; i++) begin
      int r = i / 4;
      int c = i % 4;
      int k = (r / 2) * 2 + c / 2;
      mode_avg = (i == 0) ? m0 : mrest;
      send_px(px[i], (r % 2 == 1) && (c % 2 == 1), es[k], eu[k], i == 15, lat_en);
    end
    in_valid = 1'b0;
  endtask

  function automatic frame_t inc_frame(input int base);
    frame_t f;
    for (int i = 0; i < 16; i++) f[i] = DW'(base + i + 1);
    return f;
  endfunction

  frame_t fr, fr2;
  exp4_t  ex, ex2, exu;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_out_valid", vld_s, 1'b0);
    check("rst_out_last", last_s, 1'b0);
    check("rst_out_data", data_s, 16'h0);
    check("rst_in_ready_s", in_ready_s, 1'b0);
    check("rst_in_ready_u", in_ready_u, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic raster frame, exact latency checked.
    fr = inc_frame(0);
    ex = '{16'd6, 16'd8, 16'd14, 16'd16};
    send_frame(fr, ex, ex, 1'b1, 1'b0, 1'b0);
    repeat (4) @(negedge clk);

    // Signed vs unsigned compare on the same bit patterns.
    fr  = '{16'hFFFB, 16'hFFFD, 16'h0001, 16'h8000,
            16'hFFF8, 16'hFFFF, 16'h0002, 16'h0003,
            16'h7FFF, 16'h8000, 16'h0005, 16'h0006,
            16'h0000, 16'h8001, 16'h0007, 16'h0004};
    ex  = '{16'hFFFF, 16'h0003, 16'h7FFF, 16'h0007};
    exu = '{16'hFFFF, 16'h8000, 16'h8001, 16'h0007};
    send_frame(fr, ex, exu, 1'b1, 1'b0, 1'b0);
    repeat (4) @(negedge clk);

    // Back-to-back frames with no gap.
    fr  = inc_frame(0);
    fr2 = inc_frame(100);
    ex  = '{16'd6, 16'd8, 16'd14, 16'd16};
    ex2 = '{16'd106, 16'd108, 16'd114, 16'd116};
    send_frame(fr, ex, ex, 1'b1, 1'b0, 1'b0);
    send_frame(fr2, ex2, ex2, 1'b1, 1'b0, 1'b0);
    repeat (4) @(negedge clk);

    // Downstream stall for 5 cycles while an output is pending.
    out_ready = 1'b0;
    fork
      send_frame(fr, ex, ex, 1'b0, 1'b0, 1'b0);
      begin
        int t = 0;
        int a;
        while (!vld_s && t < 100) begin
          @(negedge clk);
          t++;
        end
        if (!vld_s) begin
          check("stall_wait_valid", vld_s, 1'b1);
          out_ready = 1'b1;
        end else begin
          a = accepted;
          repeat (5) begin
            check("stall_in_ready", in_ready_s, 1'b0);
            @(negedge clk);
          end
          check("stall_no_consume", accepted, a);
          @(posedge clk);
          #2 out_ready = 1'b1;
        end
      end
    join
    repeat (4) @(negedge clk);
    check("stall_all_out_s", q_s.size(), 0);

    // Reset after 6 accepted pixels; the partial frame must vanish.
    for (int i = 0; i < 5; i++) send_px(DW'(i + 1), 1'b0, '0, '0, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = 16'd6;
    while (!in_ready_s) @(negedge clk);
    @(posedge clk);
    accepted++;
    #1 rst_n = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_out_valid", vld_s, 1'b0);
    check("midrst_out_last", last_s, 1'b0);
    check("midrst_in_ready", in_ready_s, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fr = inc_frame(0);
    ex = '{16'd6, 16'd8, 16'd14, 16'd16};
    send_frame(fr, ex, ex, 1'b1, 1'b0, 1'b0);
    repeat (4) @(negedge clk);

`ifdef POOL_AVG_EN
    // Average frame; mode dropped right after (0,0) must be ignored.
    fr  = '{16'd1, 16'd2, 16'hFFFF, 16'hFFFE,
            16'd5, 16'd6, 16'hFFFD, 16'hFFFC,
            16'd4, 16'd4, 16'h7FFF, 16'h7FFF,
            16'd4, 16'd5, 16'h7FFF, 16'h7FFF};
    ex  = '{16'd3, 16'hFFFD, 16'd4, 16'h7FFF};
    exu = '{16'd3, 16'hFFFD, 16'd4, 16'h7FFF};
    send_frame(fr, ex, exu, 1'b1, 1'b1, 1'b0);
    // Max frame; mode raised after (0,0) must be ignored.
    fr = inc_frame(0);
    ex = '{16'd6, 16'd8, 16'd14, 16'd16};
    send_frame(fr, ex, ex, 1'b1, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
`endif

    repeat (4) @(negedge clk);
    check("final_queue_s", q_s.size(), 0);
    check("final_queue_u", q_u.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
